a2d_round_robin_intf: RTL and testbench

- Periodic SPI master front-end for an ADC128S-style 8-channel, 12-bit serial A/D converter.
- Converts four analog channels one at a time in a fixed rotation.
- Holds the latest 12-bit result of each channel in its own register for the e-bike control logic.
- Sits between the system clock domain and the external ADC pins (SS_n, SCLK, MOSI, MISO).

---
 rtl/a2d_round_robin_intf.sv | 139 +++++++++++++
 tb/tb_a2d_round_robin_intf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/a2d_round_robin_intf.sv
// SPI master front-end for an ADC128S-style converter. It converts four channels
// in a fixed rotation and holds the latest 12-bit result of each channel.
module a2d_round_robin_intf #(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned SCLK_DIV_W = 5,
  parameter logic [2:0]  CH_BATT    = 3'd0,
  parameter logic [2:0]  CH_CURR    = 3'd1,
  parameter logic [2:0]  CH_BRAKE   = 3'd3,
  parameter logic [2:0]  CH_TORQUE  = 3'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque
);

  typedef enum logic [1:0] {IDLE, CMD, PAUSE, READ} state_t;

  localparam logic [SCLK_DIV_W-1:0] DIV_PRE = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_SMP = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_SHF = '1;
  localparam logic [SCLK_DIV_W-1:0] DIV_ONE = {{(SCLK_DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [SCLK_DIV_W-1:0] r_div;
  logic [15:0]           r_shift;
  logic                  r_miso_smp;
  logic [4:0]            r_bits;
  logic                  r_ss_n;
  logic [1:0]            r_ptr;
  logic [11:0]           r_batt;
  logic [11:0]           r_curr;
  logic [11:0]           r_brake;
  logic [11:0]           r_torque;

  logic                  w_active;
  logic                  w_start;
  logic                  w_done;
  logic [2:0]            w_chan;
  logic [15:0]           w_shift_nxt;

  always_comb begin
    w_active    = (r_state == CMD) || (r_state == READ);
    w_done      = w_active && (r_div == DIV_SHF) && (r_bits == 5'd16);
    w_start     = ((r_state == IDLE) && (cnt == '1)) || (r_state == PAUSE);
    w_shift_nxt = {r_shift[14:0], r_miso_smp};
    case (r_ptr)
      2'd0:    w_chan = CH_BATT;
      2'd1:    w_chan = CH_CURR;
      2'd2:    w_chan = CH_BRAKE;
      default: w_chan = CH_TORQUE;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cnt == '1) w_state_nxt = CMD;
      CMD:     if (w_done) w_state_nxt = PAUSE;
      PAUSE:   w_state_nxt = READ;
      READ:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      cnt     <= cnt + CNT_ONE;
    end
  end

  // The first divider wrap is the front porch: no bit has been sampled yet, so no shift.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ss_n     <= 1'b1;
      r_div      <= DIV_PRE;
      r_shift    <= '0;
      r_miso_smp <= 1'b0;
      r_bits     <= '0;
    end else if (w_start) begin
      r_ss_n  <= 1'b0;
      r_div   <= DIV_PRE;
      r_shift <= {2'b00, w_chan, 11'h000};
      r_bits  <= '0;
    end else if (w_done) begin
      r_ss_n  <= 1'b1;
      r_div   <= DIV_PRE;
      r_shift <= w_shift_nxt;
    end else if (w_active) begin
      r_div <= r_div + DIV_ONE;
      if (r_div == DIV_SMP) begin
        r_miso_smp <= MISO;
        r_bits     <= r_bits + 5'd1;
      end
      if ((r_div == DIV_SHF) && (r_bits != 5'd0))
        r_shift <= w_shift_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ptr    <= '0;
      r_batt   <= '0;
      r_curr   <= '0;
      r_brake  <= '0;
      r_torque <= '0;
    end else if (w_done && (r_state == READ)) begin
      case (r_ptr)
        2'd0:    r_batt   <= w_shift_nxt[11:0];
        2'd1:    r_curr   <= w_shift_nxt[11:0];
        2'd2:    r_brake  <= w_shift_nxt[11:0];
        default: r_torque <= w_shift_nxt[11:0];
      endcase
      r_ptr <= r_ptr + 2'd1;
    end
  end

  assign SS_n   = r_ss_n;
  assign SCLK   = r_div[SCLK_DIV_W-1];
  assign MOSI   = ~r_ss_n & r_shift[15];
  assign batt   = r_batt;
  assign curr   = r_curr;
  assign brake  = r_brake;
  assign torque = r_torque;

endmodule

// File: tb/tb_a2d_round_robin_intf.sv
// Scoreboard bench for a2d_round_robin_intf: an ADC model answers on MISO, and a
// frame monitor checks each SPI frame against the queue of expected frames.
module tb_a2d_round_robin_intf;

  localparam int unsigned CNT_W = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI;
  logic [11:0] batt, curr, brake, torque;

  a2d_round_robin_intf #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    bit          rd;
    logic [11:0] b, c, k, t;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] cmd, input bit rd, input logic [11:0] b,
                      input logic [11:0] c, input logic [11:0] k, input logic [11:0] t);
    exp_t e;
    e.cmd = cmd; e.rd = rd; e.b = b; e.c = c; e.k = k; e.t = t;
    q.push_back(e);
  endtask

  task automatic wait_ss(input logic v, input int budget);
    int n = 0;
    while (SS_n !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ss_wait", {31'd0, SS_n}, {31'd0, v});
  endtask

  // ADC model: answers with the channel addressed in the previous frame; channel 0
  // reads 12'h5A3 the first time and 12'h3C0 afterwards.
  logic [11:0] adc_val [8];
  logic [15:0] m_tx = '0;
  logic [15:0] m_rx = '0;
  logic [2:0]  m_prev = '0;
  int          m_rises = 0;
  int          m_ch0_reads = 0;
  bit          m_par = 1'b0;
  logic        m_ss_q = 1'b1;
  logic        m_sclk_q = 1'b1;

  initial begin
    adc_val[0] = 12'h5A3; adc_val[1] = 12'h1C7; adc_val[2] = 12'h333; adc_val[3] = 12'h824;
    adc_val[4] = 12'hFFF; adc_val[5] = 12'h333; adc_val[6] = 12'h333; adc_val[7] = 12'h333;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      m_par = 1'b0; m_rises = 0; m_ss_q = 1'b1; m_sclk_q = 1'b1; m_tx = '0; MISO = 1'b0;
    end else begin
      if (m_ss_q && !SS_n) begin
        m_tx    = {4'hC, (m_prev == 3'd0 && m_ch0_reads > 0) ? 12'h3C0 : adc_val[m_prev]};
        m_rx    = '0;
        m_rises = 0;
      end
      if (!SS_n) begin
        if (!m_sclk_q && SCLK) begin
          m_rx = {m_rx[14:0], MOSI};
          m_rises++;
        end
        if (m_sclk_q && !SCLK && m_rises > 0) m_tx = {m_tx[14:0], 1'b0};
      end
      if (!m_ss_q && SS_n) begin
        m_prev = m_rx[13:11];
        if (m_par && m_prev == 3'd0) m_ch0_reads++;
        m_par = !m_par;
      end
      MISO     = m_tx[15];
      m_ss_q   = SS_n;
      m_sclk_q = SCLK;
    end
  end

  // Frame monitor
  logic        mon_ss_q = 1'b1;
  logic        mon_sclk_q = 1'b1;
  logic [15:0] mon_rx = '0;
  int          mon_rises = 0, mon_low = 0, mon_sclk_low = 0, mon_gap = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_ss_q = 1'b1; mon_sclk_q = 1'b1; mon_gap = 0;
    end else begin
      if (mon_ss_q && !SS_n) begin
        if (q.size() > 0 && q[0].rd) check("pause_gap", mon_gap, 1);
        mon_rx = '0; mon_rises = 0; mon_low = 0; mon_sclk_low = 0;
      end
      if (!SS_n) begin
        mon_low++;
        if (!SCLK) mon_sclk_low++;
        if (!mon_sclk_q && SCLK) begin
          mon_rx = {mon_rx[14:0], MOSI};
          mon_rises++;
        end
      end else if (!mon_ss_q) begin
        check("frame_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("mosi_cmd", mon_rx, e.cmd);
          check("sclk_rises", mon_rises, 16);
          check("ss_low_len", mon_low, 521);
          check("sclk_low_len", mon_sclk_low, 256);
          check("batt", batt, e.b);
          check("curr", curr, e.c);
          check("brake", brake, e.k);
          check("torque", torque, e.t);
        end
        mon_gap = 1;
      end else begin
        mon_gap++;
      end
      mon_ss_q   = SS_n;
      mon_sclk_q = SCLK;
    end
  end

  initial begin
    int cycles;
    int lows;
    repeat (5) @(negedge clk);
    check("rst_ss_n", {31'd0, SS_n}, 32'd1);
    check("rst_sclk", {31'd0, SCLK}, 32'd1);
    check("rst_mosi", {31'd0, MOSI}, 32'd0);
    check("rst_outs", {batt, curr, brake, torque}, '0);
    lows = 0;
    repeat (3000) begin
      @(negedge clk);
      if (SS_n !== 1'b1) lows++;
    end
    check("no_spi_in_reset", lows, 0);

    push(16'h0000, 0, 12'h000, 12'h000, 12'h000, 12'h000);
    push(16'h0000, 1, 12'h5A3, 12'h000, 12'h000, 12'h000);
    push(16'h0800, 0, 12'h5A3, 12'h000, 12'h000, 12'h000);
    push(16'h0800, 1, 12'h5A3, 12'h1C7, 12'h000, 12'h000);
    push(16'h1800, 0, 12'h5A3, 12'h1C7, 12'h000, 12'h000);
    push(16'h1800, 1, 12'h5A3, 12'h1C7, 12'h824, 12'h000);
    push(16'h2000, 0, 12'h5A3, 12'h1C7, 12'h824, 12'h000);
    push(16'h2000, 1, 12'h5A3, 12'h1C7, 12'h824, 12'hFFF);
    push(16'h0000, 0, 12'h5A3, 12'h1C7, 12'h824, 12'hFFF);
    push(16'h0000, 1, 12'h3C0, 12'h1C7, 12'h824, 12'hFFF);
    push(16'h0800, 0, 12'h3C0, 12'h1C7, 12'h824, 12'hFFF);

    rst_n = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (SS_n && cycles < 5000);
    check("first_start_latency", cycles, 2048);

    // Run until only the sixth conversion's command frame is left, then abort its read frame.
    cycles = 0;
    while (q.size() > 1 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
    end
    check("five_conversions", q.size(), 1);
    wait_ss(1'b1, 3000);
    wait_ss(1'b0, 3000);
    wait_ss(1'b1, 1000);
    wait_ss(1'b0, 10);
    repeat (260) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ss_n", {31'd0, SS_n}, 32'd1);
    check("abort_sclk", {31'd0, SCLK}, 32'd1);
    check("abort_outs", {batt, curr, brake, torque}, '0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (600) @(negedge clk);
    check("no_partial_curr", curr, 12'h000);
    check("idle_after_abort", {31'd0, SS_n}, 32'd1);

    push(16'h0000, 0, 12'h000, 12'h000, 12'h000, 12'h000);
    push(16'h0000, 1, 12'h3C0, 12'h000, 12'h000, 12'h000);
    cycles = 0;
    while (q.size() != 0 && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    check("queue_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
